// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// cpu_controller : multi-cycle FSM sequencing fetch/decode/execute for a tiny
// CPU; define CTRL_JUMP_EN to enable the opcode-0110 Jump state.  Rev 1.0
// ============================================================================
module cpu_controller (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] IR_Data,
  output logic [6:0]  PC_Addr,
  output logic        IR_Id,
  output logic [7:0]  D_Addr,
  output logic        D_Wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_Addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_Addr,
  output logic [3:0]  RF_Rb_Addr,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  StateOut
);

  localparam logic [3:0] c_ST_INIT   = 4'd0;
  localparam logic [3:0] c_ST_FETCH  = 4'd1;
  localparam logic [3:0] c_ST_DECODE = 4'd2;
  localparam logic [3:0] c_ST_NOOP   = 4'd3;
  localparam logic [3:0] c_ST_LOADA  = 4'd4;
  localparam logic [3:0] c_ST_LOADB  = 4'd5;
  localparam logic [3:0] c_ST_STORE  = 4'd6;
  localparam logic [3:0] c_ST_ADD    = 4'd7;
  localparam logic [3:0] c_ST_SUB    = 4'd8;
  localparam logic [3:0] c_ST_HALT   = 4'd9;
`ifdef CTRL_JUMP_EN
  localparam logic [3:0] c_ST_JUMP   = 4'd10;
  localparam logic [3:0] c_OP_JUMP   = 4'b0110;
`endif

  localparam logic [3:0] c_OP_NOOP   = 4'b0000;
  localparam logic [3:0] c_OP_STORE  = 4'b0001;
  localparam logic [3:0] c_OP_LOAD   = 4'b0010;
  localparam logic [3:0] c_OP_ADD    = 4'b0011;
  localparam logic [3:0] c_OP_SUB    = 4'b0100;
  localparam logic [3:0] c_OP_HALT   = 4'b0101;

  localparam logic [2:0] c_ALU_PASS  = 3'b000;
  localparam logic [2:0] c_ALU_ADD   = 3'b001;
  localparam logic [2:0] c_ALU_SUB   = 3'b010;

  logic [3:0] r_state;
  logic [6:0] r_pc;
  logic [3:0] w_state_nxt;
  logic [6:0] w_pc_nxt;
  logic [3:0] w_opcode;

  assign w_opcode = IR_Data[15:12];
  assign PC_Addr  = r_pc;
  assign StateOut = r_state;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= c_ST_INIT;
      r_pc    <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      c_ST_INIT:  w_state_nxt = c_ST_FETCH;
      c_ST_FETCH: begin
        w_state_nxt = c_ST_DECODE;
        w_pc_nxt    = r_pc + 7'd1;
      end
      c_ST_DECODE: begin
        case (w_opcode)
          c_OP_NOOP:  w_state_nxt = c_ST_NOOP;
          c_OP_STORE: w_state_nxt = c_ST_STORE;
          c_OP_LOAD:  w_state_nxt = c_ST_LOADA;
          c_OP_ADD:   w_state_nxt = c_ST_ADD;
          c_OP_SUB:   w_state_nxt = c_ST_SUB;
          c_OP_HALT:  w_state_nxt = c_ST_HALT;
`ifdef CTRL_JUMP_EN
          c_OP_JUMP:  w_state_nxt = c_ST_JUMP;
`endif
          default:    w_state_nxt = c_ST_NOOP;
        endcase
      end
      c_ST_LOADA: w_state_nxt = c_ST_LOADB;
      c_ST_LOADB, c_ST_STORE, c_ST_ADD, c_ST_SUB, c_ST_NOOP:
        w_state_nxt = c_ST_FETCH;
      c_ST_HALT:  w_state_nxt = c_ST_HALT;
`ifdef CTRL_JUMP_EN
      c_ST_JUMP: begin
        w_state_nxt = c_ST_FETCH;
        w_pc_nxt    = IR_Data[6:0];
      end
`endif
      default:    w_state_nxt = c_ST_INIT;
    endcase
  end

  // Strobes are purely state-decoded so an asynchronous reset clears them at once.
  always_comb begin
    IR_Id      = 1'b0;
    D_Addr     = 8'd0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = 4'd0;
    RF_W_en    = 1'b0;
    RF_Ra_Addr = 4'd0;
    RF_Rb_Addr = 4'd0;
    ALU_s0     = c_ALU_PASS;
    case (r_state)
      c_ST_FETCH: IR_Id = 1'b1;
      c_ST_LOADA: D_Addr = IR_Data[11:4];
      c_ST_LOADB: begin
        D_Addr    = IR_Data[11:4];
        RF_s      = 1'b1;
        RF_W_Addr = IR_Data[3:0];
        RF_W_en   = 1'b1;
      end
      c_ST_STORE: begin
        RF_Ra_Addr = IR_Data[11:8];
        D_Addr     = IR_Data[7:0];
        ALU_s0     = c_ALU_PASS;
        D_Wr       = 1'b1;
      end
      c_ST_ADD, c_ST_SUB: begin
        RF_Ra_Addr = IR_Data[11:8];
        RF_Rb_Addr = IR_Data[7:4];
        RF_W_Addr  = IR_Data[3:0];
        ALU_s0     = (r_state == c_ST_ADD) ? c_ALU_ADD : c_ALU_SUB;
        RF_W_en    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// tb_cpu_controller : scoreboard bench; per-cycle expected output vectors are
// queued per instruction and popped at each negedge.  Rev 1.0
// ============================================================================
module tb_cpu_controller;

  typedef logic [37:0] vec_t;
  typedef struct {
    string tag;
    vec_t  v;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [15:0] IR_Data = 16'h0000;
  logic [6:0]  PC_Addr;
  logic        IR_Id;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic [3:0]  RF_W_Addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  StateOut;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  logic [6:0] model_pc = 7'd0;
  vec_t w_obs;

  cpu_controller u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .IR_Data(IR_Data), .PC_Addr(PC_Addr),
    .IR_Id(IR_Id), .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
    .RF_W_Addr(RF_W_Addr), .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr),
    .RF_Rb_Addr(RF_Rb_Addr), .ALU_s0(ALU_s0), .StateOut(StateOut)
  );

  always #5 Clk = ~Clk;

  assign w_obs = {StateOut, PC_Addr, IR_Id, D_Addr, D_Wr, RF_s, RF_W_Addr,
                  RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0};

  function automatic vec_t pk(input logic [3:0] st, input logic [6:0] pc,
                              input logic irid, input logic [7:0] da,
                              input logic dwr, input logic rfs,
                              input logic [3:0] wa, input logic wen,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [2:0] alu);
    return {st, pc, irid, da, dwr, rfs, wa, wen, ra, rb, alu};
  endfunction

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input string tag, input vec_t v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      check("sb_underflow", 38'd1, 38'd0);
    end else begin
      e = q.pop_front();
      check(e.tag, w_obs, e.v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      @(negedge Clk);
      pop_check();
    end
  endtask

  // Queues Fetch/Decode plus execute-state expectations; returns cycle count.
  task automatic push_instr(input logic [15:0] ir, input string tag, output int n);
    logic [6:0] p, p1;
    p  = model_pc;
    p1 = p + 7'd1;
    push({tag, "_fetch"},  pk(4'd1, p,  1'b1, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
    push({tag, "_decode"}, pk(4'd2, p1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
    n = 3;
    model_pc = p1;
    case (ir[15:12])
      4'b0010: begin
        push({tag, "_loada"}, pk(4'd4, p1, 1'b0, ir[11:4], 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
        push({tag, "_loadb"}, pk(4'd5, p1, 1'b0, ir[11:4], 1'b0, 1'b1, ir[3:0], 1'b1, 4'd0, 4'd0, 3'd0));
        n = 4;
      end
      4'b0001: push({tag, "_store"}, pk(4'd6, p1, 1'b0, ir[7:0], 1'b1, 1'b0, 4'd0, 1'b0, ir[11:8], 4'd0, 3'b000));
      4'b0011: push({tag, "_add"}, pk(4'd7, p1, 1'b0, 8'd0, 1'b0, 1'b0, ir[3:0], 1'b1, ir[11:8], ir[7:4], 3'b001));
      4'b0100: push({tag, "_sub"}, pk(4'd8, p1, 1'b0, 8'd0, 1'b0, 1'b0, ir[3:0], 1'b1, ir[11:8], ir[7:4], 3'b010));
`ifdef CTRL_JUMP_EN
      4'b0110: begin
        push({tag, "_jump"}, pk(4'd10, p1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
        model_pc = ir[6:0];
      end
`endif
      default: push({tag, "_noop"}, pk(4'd3, p1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
    endcase
  endtask

  task automatic run_instr(input logic [15:0] ir, input string tag);
    int n;
    IR_Data = ir;
    push_instr(ir, tag, n);
    step(n);
  endtask

  initial begin
    vec_t zero;
    zero = '0;

    // Reset held: Init with everything low.
    #2;
    check("reset_hold", w_obs, zero);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1 check("init_after_release", w_obs, zero);
    model_pc = 7'd0;

    run_instr(16'h0000, "noop0");
    run_instr(16'h21B5, "load");
    run_instr(16'h3123, "add");
    run_instr(16'h1A42, "store");
    run_instr(16'h4ABC, "sub");
    run_instr(16'hF123, "badop");
    run_instr(16'h7FFF, "badop7");
    run_instr(16'h6045, "jump");
    run_instr(16'h0000, "post_jump");

    for (int i = 0; i < 128; i++) run_instr(16'h0000, "wrap");
    check("wrap_pc_roundtrip", {31'd0, PC_Addr}, {31'd0, model_pc});

    // Reset during LoadB must kill the register-file write immediately.
    begin
      int n;
      IR_Data = 16'h2FF7;
      push_instr(16'h2FF7, "rst_load", n);
      step(3);
      @(posedge Clk);
      #1 pop_check();
      #1 Reset_n = 1'b0;
      #1 check("rst_in_loadb", w_obs, zero);
      @(negedge Clk);
      Reset_n = 1'b1;
      model_pc = 7'd0;
      #1 check("rst_loadb_init", w_obs, zero);
    end
    check("sb_empty_after_rst", vec_t'(q.size()), 38'd0);
    run_instr(16'h0000, "recover");

    // Halt must absorb for 50 cycles with PC frozen.
    begin
      int n;
      logic [6:0] p1;
      IR_Data = 16'h5000;
      push_instr(16'h5000, "halt", n);
      void'(q.pop_back());
      p1 = model_pc;
      for (int i = 0; i < 50; i++)
        push("halt_hold", pk(4'd9, p1, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0));
      step(52);
    end

    @(posedge Clk);
    #2 Reset_n = 1'b0;
    #1 check("async_reset_midclk", w_obs, zero);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_pc = 7'd0;
    run_instr(16'h3456, "add_after_halt");

    check("sb_empty_end", vec_t'(q.size()), 38'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
